// File: rtl/a1csa_pkg.sv
// Shared helpers for the add-one carry-select pipeline: block-count function and
// the encoding used for per-stage valid flags.
package a1csa_pkg;

  function automatic int unsigned nblk(input int unsigned w, input int unsigned b);
    return w / b;
  endfunction

  localparam logic StageEmpty = 1'b0;
  localparam logic StageFull  = 1'b1;

endpackage

// File: rtl/a1csa_blk.sv
// Combinational B-bit block: uncarried sum with generate/propagate flags, plus an
// add-one select that yields s0 or s0+1 depending on the incoming block carry.
module a1csa_blk #(
  parameter int unsigned B = 4
) (
  input  logic [B-1:0] a,
  input  logic [B-1:0] b,
  input  logic         sel,
  output logic [B-1:0] s0,
  output logic         gen,
  output logic         prop,
  output logic [B-1:0] rs
);

  always_comb begin
    {gen, s0} = {1'b0, a} + {1'b0, b};
    prop      = &s0;
    rs        = sel ? (s0 + B'(1)) : s0;
  end

endmodule

// File: rtl/a1csa_pipe.sv
// Two-stage pipelined add-one carry-select adder/subtractor with valid/ready handshake.
// Stage 1 registers per-block sums and g/p flags; stage 2 resolves the block carry chain.
module a1csa_pipe
  import a1csa_pkg::*;
#(
  parameter int unsigned W = 16,
  parameter int unsigned B = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned NB = nblk(W, B);

  if ((W % B) != 0 || B < 2 || W < B) begin : g_param_check
    $error("a1csa_pipe: W must be a multiple of B, with W >= B and B >= 2");
  end

  logic [W-1:0]         bb;
  logic [NB-1:0][B-1:0] s0_c, s0_q, res_c;
  logic [NB-1:0]        g_c, p_c, g_q, p_q;
  logic [NB:0]          c;
  logic                 eff_cin_q, xmsb_q, v1_q, v2_q;
  logic                 stage1_ready, stage2_ready, in_fire, c_into_msb;
  logic [W-1:0]         s_q;
  logic                 cout_q, ovf_q;

  // Outputs the block exposes that a given instance has no use for.
  logic [NB-1:0][B-1:0] unused_rs1, unused_s0_2;
  logic [NB-1:0]        unused_g2, unused_p2;

  assign bb = sub ? ~b : b;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    a1csa_blk #(.B(B)) u_stage1 (
      .a    (a[k*B +: B]),
      .b    (bb[k*B +: B]),
      .sel  (1'b0),
      .s0   (s0_c[k]),
      .gen  (g_c[k]),
      .prop (p_c[k]),
      .rs   (unused_rs1[k])
    );

    a1csa_blk #(.B(B)) u_stage2 (
      .a    (s0_q[k]),
      .b    ('0),
      .sel  (c[k]),
      .s0   (unused_s0_2[k]),
      .gen  (unused_g2[k]),
      .prop (unused_p2[k]),
      .rs   (res_c[k])
    );
  end

  always_comb begin
    c    = '0;
    c[0] = eff_cin_q;
    for (int k = 0; k < NB; k++) begin
      c[k+1] = g_q[k] | (p_q[k] & c[k]);
    end
  end

  // Result MSB = a^bb^carry-in at that bit, so the carry into the MSB falls out of an XOR.
  assign c_into_msb = res_c[NB-1][B-1] ^ xmsb_q;

  assign stage2_ready = (v2_q == StageEmpty) | out_ready;
  assign stage1_ready = (v1_q == StageEmpty) | stage2_ready;
  assign in_ready     = stage1_ready & ~rst;
  assign in_fire      = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s0_q      <= s0_c;
      g_q       <= g_c;
      p_q       <= p_c;
      eff_cin_q <= sub | cin;
      xmsb_q    <= a[W-1] ^ bb[W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= StageEmpty;
      v2_q   <= StageEmpty;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (in_fire) begin
        v1_q <= StageFull;
      end else if (stage2_ready) begin
        v1_q <= StageEmpty;
      end
      if (stage2_ready) begin
        v2_q <= v1_q;
        if (v1_q == StageFull) begin
          s_q    <= res_c;
          cout_q <= c[NB];
          ovf_q  <= c_into_msb ^ c[NB];
        end
      end
    end
  end

  assign out_valid = v2_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_a1csa_pipe.sv
// Self-checking bench: directed vectors, backpressure and reset sequences on W=16/B=4,
// then randomized streams on three widths scored against a plain-arithmetic model.
module tb_a1csa_pipe;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv[3], ordy[3], cin_v[3], sub_v[3];
  logic [31:0] a_v[3], b_v[3];
  wire  [2:0]  ir_w, ov_w, co_w, of_w;
  wire  [15:0] s16;
  wire  [31:0] s32;
  wire  [7:0]  s8;

  int checks, errors;
  res_t exp_arr[3][0:9999];
  int   wr[3], rd[3];

  a1csa_pipe #(.W(16), .B(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir_w[0]),
    .a(a_v[0][15:0]), .b(b_v[0][15:0]), .cin(cin_v[0]), .sub(sub_v[0]),
    .out_valid(ov_w[0]), .out_ready(ordy[0]), .s(s16), .cout(co_w[0]), .ovf(of_w[0])
  );

  a1csa_pipe #(.W(32), .B(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir_w[1]),
    .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .sub(sub_v[1]),
    .out_valid(ov_w[1]), .out_ready(ordy[1]), .s(s32), .cout(co_w[1]), .ovf(of_w[1])
  );

  a1csa_pipe #(.W(8), .B(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir_w[2]),
    .a(a_v[2][7:0]), .b(b_v[2][7:0]), .cin(cin_v[2]), .sub(sub_v[2]),
    .out_valid(ov_w[2]), .out_ready(ordy[2]), .s(s8), .cout(co_w[2]), .ovf(of_w[2])
  );

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                 input logic sub, input int w);
    longint unsigned m, aa, bb, full;
    res_t r;
    m    = (64'd1 << w) - 64'd1;
    aa   = {32'b0, a} & m;
    bb   = {32'b0, b};
    bb   = sub ? (~bb & m) : (bb & m);
    full = aa + bb + ((sub || cin) ? 64'd1 : 64'd0);
    r.s  = 32'(full & m);
    r.c  = full[w];
    // Signed overflow: operands share a sign and the result's sign differs.
    r.o  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return r;
  endfunction

  function automatic logic [31:0] get_s(input int id);
    case (id)
      0:       return {16'b0, s16};
      1:       return s32;
      default: return {24'b0, s8};
    endcase
  endfunction

  function automatic logic [63:0] got(input int id);
    return {30'b0, get_s(id), co_w[id], of_w[id]};
  endfunction

  function automatic logic [63:0] pack(input res_t r);
    return {30'b0, r.s, r.c, r.o};
  endfunction

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expect_v);
    checks++;
    if (actual !== expect_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, expect_v);
    end
  endtask

  task automatic send_vec(input vec_t v);
    res_t e;
    e = '{s: {16'b0, v.s}, c: v.c, o: v.o};
    @(negedge clk);
    ordy[0] = 1'b1;
    iv[0] = 1'b1; a_v[0] = {16'b0, v.a}; b_v[0] = {16'b0, v.b};
    cin_v[0] = v.cin; sub_v[0] = v.sub;
    #2 chk("vec_in_ready", 64'(ir_w[0]), 64'd1);
    @(negedge clk);
    iv[0] = 1'b0; a_v[0] = 'x; b_v[0] = 'x;
    #2 chk("vec_lat1_not_valid", 64'(ov_w[0]), 64'd0);
    @(negedge clk);
    #2 chk("vec_lat2_valid", 64'(ov_w[0]), 64'd1);
    chk("vec_result", got(0), pack(e));
  endtask

  task automatic bp_test();
    res_t        e[5];
    logic [15:0] ta[5], tb[5];
    int          sent, rcv;
    bit          saw_low;
    sent = 0; rcv = 0; saw_low = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ta[i] = 16'($urandom);
      tb[i] = 16'($urandom);
      e[i]  = model({16'b0, ta[i]}, {16'b0, tb[i]}, 1'b0, i[0], 16);
    end
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      ordy[0] = !(cyc >= 3 && cyc <= 6);
      if (sent < 5) begin
        iv[0] = 1'b1; a_v[0] = {16'b0, ta[sent]}; b_v[0] = {16'b0, tb[sent]};
        cin_v[0] = 1'b0; sub_v[0] = sent[0];
      end else begin
        iv[0] = 1'b0;
      end
      #2;
      if (iv[0] && !ir_w[0]) saw_low = 1'b1;
      if (ov_w[0] && !ordy[0] && rcv < 5) chk("bp_stall_hold", got(0), pack(e[rcv]));
      if (ov_w[0] && ordy[0]) begin
        if (rcv < 5) chk("bp_beat", got(0), pack(e[rcv]));
        else chk("bp_extra_beat", 64'd1, 64'd0);
        rcv++;
      end
      if (iv[0] && ir_w[0]) sent++;
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    chk("bp_count", 64'(rcv), 64'd5);
    chk("bp_in_ready_fell", 64'(saw_low), 64'd1);
  endtask

  task automatic rst_test();
    @(negedge clk);
    ordy[0] = 1'b0; iv[0] = 1'b1; a_v[0] = 32'h1111; b_v[0] = 32'h2222;
    cin_v[0] = 1'b0; sub_v[0] = 1'b0;
    @(negedge clk);
    a_v[0] = 32'h3333; b_v[0] = 32'h4444;
    @(negedge clk);
    #2 chk("rst_pre_valid", 64'(ov_w[0]), 64'd1);
    // Operands offered while reset is held must be dropped.
    rst = 1'b1; a_v[0] = 32'h5555; b_v[0] = 32'h6666;
    @(negedge clk);
    #2;
    chk("rst_out_valid", 64'(ov_w[0]), 64'd0);
    chk("rst_outputs", got(0), 64'd0);
    rst = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #2 chk("rst_no_stale", 64'(ov_w[0]), 64'd0);
    end
    chk("rst_in_ready", 64'(ir_w[0]), 64'd1);
  endtask

  task automatic drive_rand(input int id, input int w, input int n);
    int cyc;
    bit pend;
    cyc = 0; pend = 1'b0; wr[id] = 0;
    while (wr[id] < n && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (!pend) begin
        a_v[id] = $urandom; b_v[id] = $urandom;
        cin_v[id] = 1'($urandom); sub_v[id] = 1'($urandom);
        iv[id] = ($urandom_range(0, 3) != 0);
        pend = iv[id];
      end
      #2;
      if (iv[id] && ir_w[id]) begin
        exp_arr[id][wr[id]] = model(a_v[id], b_v[id], cin_v[id], sub_v[id], w);
        wr[id]++;
        pend = 1'b0;
      end
    end
    @(negedge clk);
    iv[id] = 1'b0;
    chk("rand_sent", 64'(wr[id]), 64'(n));
  endtask

  task automatic mon_rand(input int id, input int n);
    int cyc;
    cyc = 0; rd[id] = 0;
    while (rd[id] < n && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      ordy[id] = ($urandom_range(0, 3) != 0);
      #2;
      if (ov_w[id] && ordy[id]) begin
        if (rd[id] >= wr[id]) chk("rand_spurious", 64'd1, 64'd0);
        else chk("rand_beat", got(id), pack(exp_arr[id][rd[id]]));
        rd[id]++;
      end
    end
    ordy[id] = 1'b1;
    chk("rand_received", 64'(rd[id]), 64'(n));
  endtask

  vec_t vecs[10];

  initial begin
    checks = 0; errors = 0;
    vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[8] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
    vecs[9] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; a_v[i] = '0; b_v[i] = '0;
      cin_v[i] = 1'b0; sub_v[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("reset_out_valid", 64'(ov_w[i]), 64'd0);
      chk("reset_outputs", got(i), 64'd0);
      chk("reset_in_ready", 64'(ir_w[i]), 64'd1);
    end

    for (int i = 0; i < 10; i++) send_vec(vecs[i]);
    bp_test();
    rst_test();

    fork
      drive_rand(0, 16, 2000);
      mon_rand(0, 2000);
      drive_rand(1, 32, 10000);
      mon_rand(1, 10000);
      drive_rand(2, 8, 10000);
      mon_rand(2, 10000);
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
